// File: rtl/ppm4_symbol_decoder_if.sv
// ppm4_symbol_decoder_if
// Groups the decoder's line-side inputs and its byte-assembler/controller
// outputs into one bundle.
//   clk16          sampling strobe, one clk wide
//   ppm_in         raw serial 4-PPM line (asynchronous to clk)
//   rx_en          receive enable
//   data_3bits_in  [1:0] decoded symbol, [2] symbol error flag
//   finish2bits    symbol-complete strobe, held for one clk16 period
//   frame_active   high while decoding frame data
//   frame_end      one-clk16-period pulse when a frame ends on an empty symbol
//   sym_err        sticky per-frame symbol error indication
// Modports: master = the decoder, slave = the line driver / consumers.
interface ppm4_symbol_decoder_if;
    logic       clk16;
    logic       ppm_in;
    logic       rx_en;
    logic [2:0] data_3bits_in;
    logic       finish2bits;
    logic       frame_active;
    logic       frame_end;
    logic       sym_err;

    modport master (
        input  clk16, ppm_in, rx_en,
        output data_3bits_in, finish2bits, frame_active, frame_end, sym_err
    );

    modport slave (
        output clk16, ppm_in, rx_en,
        input  data_3bits_in, finish2bits, frame_active, frame_end, sym_err
    );
endinterface

// File: rtl/ppm4_symbol_decoder.sv
// ppm4_symbol_decoder
// Front end of the PPM receive path. Oversamples the 4-PPM line on clk16
// ticks, qualifies the frame start pulse, majority-decodes each 4-chip
// symbol into a 2-bit value and hands it to the byte assembler.
// Ports:
//   clk    system clock, all flops on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    ppm4_symbol_decoder_if.master (line inputs, decoded outputs)
module ppm4_symbol_decoder #(
    parameter int CHIP_TICKS  = 4,
    parameter int START_TICKS = 4,
    parameter int ON_THRESH   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ppm4_symbol_decoder_if.master        bus
);

    localparam int TW = $clog2(CHIP_TICKS);
    localparam int OW = $clog2(CHIP_TICKS + 1);
    localparam int HW = $clog2(START_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CHIP_TICKS - 1);
    localparam logic [OW-1:0] ON_MIN    = OW'(ON_THRESH);
    localparam logic [HW-1:0] START_MIN = HW'(START_TICKS);

    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    state_t          state, state_n;
    logic            sync1, sync2;
    logic [HW-1:0]   high_cnt, high_cnt_n;
    logic [TW-1:0]   tick_cnt, tick_cnt_n;
    logic [OW-1:0]   on_cnt, on_cnt_n, on_sum;
    logic [1:0]      chip, chip_n;
    logic [2:0]      chip_on, chip_on_n;
    logic [2:0]      data_q, data_n;
    logic            finish_q, finish_n;
    logic            end_q, end_n;
    logic            err_q, err_n;
    logic            chip_dec;
    logic [3:0]      sym_chips;
    logic [1:0]      low_idx;
    logic            sym_any, sym_multi;

    // Two-flop synchronizer on the raw line; runs every clk, not only on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.ppm_in;
            sync2 <= sync1;
        end
    end

    // The current tick's sample is folded into the chip decision so the
    // decision for the last tick of a chip is available on that same tick.
    // Chip 3 never needs storing: it is only used on the evaluating tick.
    assign on_sum    = on_cnt + OW'(sync2);
    assign chip_dec  = (on_sum >= ON_MIN);
    assign sym_chips = {chip_dec, chip_on};
    assign sym_any   = |sym_chips;
    assign sym_multi = ($countones(sym_chips) > 1);

    // Lowest-index "on" chip; scanning downward leaves the lowest one last.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (sym_chips[i]) low_idx = 2'(i);
        end
    end

    // State register and all counters/outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            high_cnt <= '0;
            tick_cnt <= '0;
            on_cnt   <= '0;
            chip     <= 2'd0;
            chip_on  <= 3'd0;
            data_q   <= 3'd0;
            finish_q <= 1'b0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            high_cnt <= high_cnt_n;
            tick_cnt <= tick_cnt_n;
            on_cnt   <= on_cnt_n;
            chip     <= chip_n;
            chip_on  <= chip_on_n;
            data_q   <= data_n;
            finish_q <= finish_n;
            end_q    <= end_n;
            err_q    <= err_n;
        end
    end

    // Next-state logic. Nothing moves without a tick; finish2bits and
    // frame_end are cleared on every tick so they last one clk16 period.
    always_comb begin
        state_n    = state;
        high_cnt_n = high_cnt;
        tick_cnt_n = tick_cnt;
        on_cnt_n   = on_cnt;
        chip_n     = chip;
        chip_on_n  = chip_on;
        data_n     = data_q;
        finish_n   = finish_q;
        end_n      = end_q;
        err_n      = err_q;

        if (bus.clk16) begin
            finish_n = 1'b0;
            end_n    = 1'b0;
            if (!bus.rx_en) begin
                // Abort: partial symbol discarded, sym_err left as is.
                state_n    = IDLE;
                high_cnt_n = '0;
                tick_cnt_n = '0;
                on_cnt_n   = '0;
                chip_n     = 2'd0;
                chip_on_n  = 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sync2) begin
                            state_n    = START;
                            high_cnt_n = HW'(1);
                        end else begin
                            high_cnt_n = '0;
                        end
                    end
                    START: begin
                        if (sync2) begin
                            if (high_cnt < START_MIN) high_cnt_n = HW'(high_cnt + 1'b1);
                        end else begin
                            high_cnt_n = '0;
                            if (high_cnt >= START_MIN) begin
                                state_n    = DATA;
                                tick_cnt_n = '0;
                                on_cnt_n   = '0;
                                chip_n     = 2'd0;
                                chip_on_n  = 3'd0;
                                err_n      = 1'b0;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                    DATA: begin
                        if (tick_cnt != TICK_LAST) begin
                            tick_cnt_n = tick_cnt + 1'b1;
                            on_cnt_n   = on_sum;
                        end else begin
                            tick_cnt_n = '0;
                            on_cnt_n   = '0;
                            chip_n     = chip + 1'b1;
                            if (chip != 2'd3) begin
                                chip_on_n = chip_on | ({2'b00, chip_dec} << chip);
                            end else begin
                                chip_on_n = 3'd0;
                                if (!sym_any) begin
                                    // Empty symbol terminates the frame.
                                    end_n   = 1'b1;
                                    state_n = IDLE;
                                end else begin
                                    finish_n = 1'b1;
                                    data_n   = {sym_multi, low_idx};
                                    if (sym_multi) err_n = 1'b1;
                                end
                            end
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    assign bus.data_3bits_in = data_q;
    assign bus.finish2bits   = finish_q;
    assign bus.frame_active  = (state == DATA);
    assign bus.frame_end     = end_q;
    assign bus.sym_err       = err_q;

endmodule

// File: tb/tb_ppm4_symbol_decoder.sv
// tb_ppm4_symbol_decoder
// Drives the 4-PPM line one clk16 tick at a time (clk16 high one clk in four)
// and records what a consumer sees: every finish2bits/frame_end value that is
// present while clk16=1. Expectations come from directed constants and from a
// chip-majority reference model of the symbol rules.
module tb_ppm4_symbol_decoder;

    localparam int CT    = 4;
    localparam int ON_TH = 2;

    logic clk = 1'b0;
    logic rst_n;

    ppm4_symbol_decoder_if bus ();

    ppm4_symbol_decoder #(
        .CHIP_TICKS  (CT),
        .START_TICKS (4),
        .ON_THRESH   (ON_TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] obs_q[$];
    logic [2:0] exp_q[$];
    int         end_seen;
    int         active_seen;

    // One clk16 tick: the line value is set three clks ahead so it has
    // crossed the synchronizer by the tick edge.
    task automatic applyStimulus(input logic p, input logic en);
        bus.ppm_in = p;
        bus.rx_en  = en;
        bus.clk16  = 1'b0;
        repeat (3) @(negedge clk);
        bus.clk16 = 1'b1;
        if (bus.finish2bits) obs_q.push_back(bus.data_3bits_in);
        if (bus.frame_end) end_seen++;
        @(negedge clk);
        bus.clk16 = 1'b0;
        if (bus.frame_active) active_seen++;
    endtask

    task automatic send_start(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic send_symbol(input logic [15:0] smp);
        for (int i = 0; i < 4 * CT; i++) applyStimulus(smp[i], 1'b1);
    endtask

    task automatic clear_log();
        obs_q.delete();
        exp_q.delete();
        end_seen    = 0;
        active_seen = 0;
    endtask

    // Reference: a chip is on when at least ON_TH of its samples are high.
    // Returns {non-empty, error, lowest on chip}.
    function automatic logic [3:0] sym_result(input logic [15:0] smp);
        int ons = 0;
        int low = -1;
        for (int c = 0; c < 4; c++) begin
            int k = 0;
            for (int i = 0; i < CT; i++) k += int'(smp[c*CT+i]);
            if (k >= ON_TH) begin
                ons++;
                if (low < 0) low = c;
            end
        end
        if (ons == 0) return 4'b0000;
        return {1'b1, (ons > 1), 2'(low)};
    endfunction

    function automatic logic [3:0] rand_chip(input bit on);
        logic [3:0] v;
        do v = 4'($urandom);
        while (on ? ($countones(v) < ON_TH) : ($countones(v) >= ON_TH));
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.clk16 = 1'b0; bus.ppm_in = 1'b0; bus.rx_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.data_3bits_in !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_data: got %b expected 000", bus.data_3bits_in); end
        n_checks++; if (bus.finish2bits !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_finish: got %b expected 0", bus.finish2bits); end
        n_checks++; if (bus.frame_active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active: got %b expected 0", bus.frame_active); end
        n_checks++; if (bus.frame_end !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_end: got %b expected 0", bus.frame_end); end
        n_checks++; if (bus.sym_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sym_err: got %b expected 0", bus.sym_err); end
        rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b1);
    endtask

    task automatic test_basic();
        clear_log();
        send_start(4);
        n_checks++; if (bus.frame_active !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_active: got %b expected 1", bus.frame_active); end
        send_symbol(16'h0F00); exp_q.push_back(3'b010);
        send_symbol(16'h000F); exp_q.push_back(3'b000);
        send_symbol(16'hF000); exp_q.push_back(3'b011);
        send_symbol(16'h00F0); exp_q.push_back(3'b001);
        send_symbol(16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL basic_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL basic_sym%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (end_seen != 1) begin n_fail++; $display("[TB] FAIL basic_frame_end: got %0d expected 1", end_seen); end
        n_checks++; if (bus.frame_active !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_active_end: got %b expected 0", bus.frame_active); end
        n_checks++; if (bus.sym_err !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_sym_err: got %b expected 0", bus.sym_err); end
    endtask

    task automatic test_short_start();
        clear_log();
        send_start(3);
        repeat (20) applyStimulus(1'b0, 1'b1);
        n_checks++; if (active_seen != 0) begin n_fail++; $display("[TB] FAIL short_active: got %0d expected 0", active_seen); end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL short_strobes: got %0d expected 0", obs_q.size()); end
        n_checks++; if (end_seen != 0) begin n_fail++; $display("[TB] FAIL short_frame_end: got %0d expected 0", end_seen); end
    endtask

    task automatic test_error();
        clear_log();
        send_start(4);
        send_symbol(16'hF0F0); exp_q.push_back(3'b101);
        n_checks++; if (bus.sym_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set: got %b expected 1", bus.sym_err); end
        send_symbol(16'h000F); exp_q.push_back(3'b000);
        n_checks++; if (bus.sym_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", bus.sym_err); end
        send_symbol(16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL err_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL err_sym%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.sym_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_after_frame: got %b expected 1", bus.sym_err); end
    endtask

    task automatic test_glitch();
        clear_log();
        send_start(4);
        n_checks++; if (bus.sym_err !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_err_cleared: got %b expected 0", bus.sym_err); end
        send_symbol(16'h0F01); exp_q.push_back(3'b010);
        send_symbol(16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL glitch_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL glitch_sym%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.sym_err !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_sym_err: got %b expected 0", bus.sym_err); end
    endtask

    task automatic test_rx_abort();
        logic [15:0] partial;
        clear_log();
        partial = 16'h00FF;
        send_start(4);
        send_symbol(16'h00F0); exp_q.push_back(3'b001);
        for (int i = 0; i < 7; i++) applyStimulus(partial[i], 1'b1);
        applyStimulus(1'b1, 1'b0);
        n_checks++; if (bus.frame_active !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_active: got %b expected 0", bus.frame_active); end
        repeat (10) applyStimulus(1'b0, 1'b0);
        n_checks++; if (bus.finish2bits !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_finish: got %b expected 0", bus.finish2bits); end
        n_checks++; if (end_seen != 0) begin n_fail++; $display("[TB] FAIL abort_frame_end: got %0d expected 0", end_seen); end
        send_start(4);
        send_symbol(16'hF000); exp_q.push_back(3'b011);
        send_symbol(16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL abort_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL abort_sym%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (end_seen != 1) begin n_fail++; $display("[TB] FAIL abort_fresh_end: got %0d expected 1", end_seen); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] partial;
        clear_log();
        partial = 16'h00F0;
        send_start(4);
        send_symbol(16'h0F0F); exp_q.push_back(3'b100);
        for (int i = 0; i < 6; i++) applyStimulus(partial[i], 1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.finish2bits !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_finish: got %b expected 0", bus.finish2bits); end
        n_checks++; if (bus.data_3bits_in !== 3'b000) begin n_fail++; $display("[TB] FAIL rstmid_data: got %b expected 000", bus.data_3bits_in); end
        n_checks++; if (bus.frame_active !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_active: got %b expected 0", bus.frame_active); end
        n_checks++; if (bus.sym_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_sym_err: got %b expected 0", bus.sym_err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) applyStimulus(1'b0, 1'b1);
        n_checks++; if (end_seen != 0) begin n_fail++; $display("[TB] FAIL rstmid_frame_end: got %0d expected 0", end_seen); end
        send_start(4);
        send_symbol(16'h0F00); exp_q.push_back(3'b010);
        send_symbol(16'h0000);
        repeat (2) applyStimulus(1'b0, 1'b1);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rstmid_strobes: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rstmid_sym%0d: got %b expected %b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            logic        err_exp;
            int          nsym;
            clear_log();
            err_exp = 1'b0;
            nsym    = 2 + int'($urandom_range(0, 3));
            send_start(4 + int'($urandom_range(0, 2)));
            for (int s = 0; s < nsym; s++) begin
                logic [3:0]  mask;
                logic [15:0] smp;
                logic [3:0]  r;
                if ($urandom_range(0, 3) == 0) begin
                    do mask = 4'($urandom); while ($countones(mask) < 2);
                end else begin
                    mask = 4'b0001 << $urandom_range(0, 3);
                end
                for (int c = 0; c < 4; c++) smp[c*CT +: 4] = rand_chip(mask[c]);
                r = sym_result(smp);
                exp_q.push_back(r[2:0]);
                if (r[2]) err_exp = 1'b1;
                send_symbol(smp);
            end
            send_symbol(16'h0000);
            repeat (2) applyStimulus(1'b0, 1'b1);
            n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rand%0d_strobes: got %0d expected %0d", f, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rand%0d_sym%0d: got %b expected %b", f, i, obs_q[i], exp_q[i]); end
            end
            n_checks++; if (end_seen != 1) begin n_fail++; $display("[TB] FAIL rand%0d_frame_end: got %0d expected 1", f, end_seen); end
            n_checks++; if (bus.sym_err !== err_exp) begin n_fail++; $display("[TB] FAIL rand%0d_sym_err: got %b expected %b", f, bus.sym_err, err_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_start();
        test_error();
        test_glitch();
        test_rx_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppm4_symbol_decoder.md
Name: ppm4_symbol_decoder

Overview:
Front-end stage of the PPM receive path: oversamples the serial 4-PPM line on the clk16 strobe, finds frame start and decodes each 4-chip symbol into a 2-bit value. Drives the byte assembler directly through data_3bits_in / finish2bits (2-bit symbol, error flag, completion strobe aligned to clk16). Also reports frame boundaries and symbol errors to the receive controller.

Parameters:
CHIP_TICKS, 4, clk16 ticks per chip (symbol = 4*CHIP_TICKS ticks); minimum 2, power of two.
START_TICKS, 4, consecutive high ticks needed to qualify the start pulse.
ON_THRESH, 2, minimum high samples within a chip for the chip to count as "on" (1..CHIP_TICKS).

Ports:
clk  input  1  system clock; all flops on posedge clk.
rst_n  input  1  asynchronous active-low reset.
clk16  input  1  one-clk-wide sampling strobe; all state advances only in cycles with clk16=1.
ppm_in  input  1  raw serial PPM line, asynchronous to clk.
rx_en  input  1  receive enable; 0 forces IDLE at the next tick.
data_3bits_in  output  3  [1:0] decoded symbol, [2] symbol error flag.
finish2bits  output  1  symbol-complete flag, held for exactly one clk16 period.
frame_active  output  1  high while in DATA state.
frame_end  output  1  one-clk16-period pulse when the frame terminates on an empty symbol.
sym_err  output  1  sticky per frame: any errored symbol since frame start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0, synchronizer flops 0, data_3bits_in=3'b000, finish2bits=0, frame_active=0, frame_end=0, sym_err=0.
- ppm_in passes through a 2-flop synchronizer clocked every clk; sample s = synchronizer output taken on ticks (clk16=1). Synchronizer adds 2 clk latency, ignored by tick logic.
- States: IDLE, START, DATA.
- IDLE: high_cnt=0. Tick with rx_en=1 and s=1 -> START with high_cnt=1.
- START: tick with s=1 -> high_cnt++ (saturate at START_TICKS). Tick with s=0: if high_cnt>=START_TICKS -> DATA, chip=0, tick_cnt=0, sym_err cleared; else -> IDLE (glitch rejected). The tick that sees s=0 is not a data sample; the next tick is sample 0 of chip 0.
- DATA: per tick, tick_cnt++; on_cnt += s. When tick_cnt==CHIP_TICKS-1: chip_on[chip] = (on_cnt+s >= ON_THRESH), on_cnt=0, tick_cnt=0, chip++ (2-bit wrap).
- Symbol evaluation at the last tick of chip 3 (same tick the chip-3 decision is made): exactly one chip on -> data_3bits_in={1'b0, chip index}; two or more on -> data_3bits_in={1'b1, index of lowest on chip}, sym_err=1; zero on -> end of frame: no finish2bits, frame_end=1, -> IDLE.
- finish2bits and data_3bits_in update on the evaluating tick's clock edge; finish2bits stays 1 until the next tick's edge, so the consumer sees finish2bits=1 with clk16=1 exactly once. data_3bits_in holds its value until the next evaluation.
- Symbols decode back-to-back with no gap; frame_active=1 throughout DATA, drops on the same edge frame_end rises.
- rx_en=0 at any tick: -> IDLE, partial symbol discarded, no finish2bits, no frame_end; frame_active drops on that edge. sym_err holds its value.
- Reset mid-symbol: everything returns to reset values immediately; no spurious strobe after release.
- clk16=0 cycles: no state change except that finish2bits/frame_end simply hold.
- Chip decisions use majority counting only; no resync within a frame (drift is the transmitter's responsibility).

Test Plan:
- Start pulse of 4 ticks high, then symbols with pulse in chip 2, 0, 3, 1 (CHIP_TICKS=4) -> four finish2bits strobes with data_3bits_in = 3'b010, 3'b000, 3'b011, 3'b001; each strobe overlaps exactly one clk16=1 cycle.
- Start pulse of only 3 high ticks -> returns to IDLE, frame_active never rises, no strobes.
- Symbol with chips 1 and 3 both high -> data_3bits_in=3'b101, finish2bits pulses, sym_err=1 and stays 1 for rest of frame.
- Chip with single-tick glitch (1 of 4 samples high) plus real pulse in chip 2 -> data_3bits_in=3'b010, no error.
- Two valid symbols followed by an all-low symbol -> two strobes, then frame_end for one clk16 period, frame_active=0, state IDLE; next valid start pulse clears sym_err.
- rx_en dropped mid-symbol, and separately rst_n asserted mid-symbol -> no finish2bits for the partial symbol, all outputs at reset/idle values, clean decode of a fresh frame afterwards.
